// File: rtl/eeprom_access_arb.sv
// Two-requester round-robin arbiter in front of an I2C EEPROM driver.
// Each command runs issue -> wait for driver -> optional write-cycle wait -> response.
module eeprom_access_arb #(
  parameter logic        BIT_CTRL    = 1'b1,
  parameter logic [15:0] WR_WAIT_CYC = 16'd5000,
  parameter logic [15:0] TIMEOUT_CYC = 16'd4000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic        req0_rh_wl,
  input  logic [15:0] req0_addr,
  input  logic [7:0]  req0_wdata,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic        req1_rh_wl,
  input  logic [15:0] req1_addr,
  input  logic [7:0]  req1_wdata,
  output logic        req1_ready,
  output logic        resp0_valid,
  output logic        resp1_valid,
  output logic [7:0]  resp_rdata,
  output logic        resp_err,
  output logic        i2c_exec,
  output logic        bit_ctrl,
  output logic        i2c_rh_wl,
  output logic [15:0] i2c_addr,
  output logic [7:0]  i2c_data_w,
  input  logic [7:0]  i2c_data_r,
  input  logic        i2c_done,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_DONE, WR_WAIT, RESP} state_t;

  localparam logic [15:0] WR_LAST = (WR_WAIT_CYC == 16'd0) ? 16'd0 : WR_WAIT_CYC - 16'd1;
  localparam logic [15:0] TO_LAST = TIMEOUT_CYC - 16'd1;

  state_t      state_q, state_d;
  logic        grant_id_q, grant_id_d;
  logic        last_grant_q, last_grant_d;
  logic        rh_wl_q, rh_wl_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [15:0] cnt_q, cnt_d;
  logic        grant0, grant1;

  // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    rh_wl_d      = rh_wl_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    cnt_d        = cnt_q;
    grant0       = 1'b0;
    grant1       = 1'b0;

    case (state_q)
      IDLE: begin
        // With both requesting, the one that did not go last wins.
        grant0 = !rst && req0_valid && (!req1_valid || last_grant_q);
        grant1 = !rst && req1_valid && !grant0;
        if (grant0 || grant1) begin
          grant_id_d = grant1;
          rh_wl_d    = grant1 ? req1_rh_wl : req0_rh_wl;
          addr_d     = grant1 ? req1_addr  : req0_addr;
          wdata_d    = grant1 ? req1_wdata : req0_wdata;
          rdata_d    = 8'h00;
          err_d      = 1'b0;
          cnt_d      = 16'd0;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        // Counter holds cycles elapsed since the i2c_exec pulse.
        cnt_d   = 16'd1;
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (i2c_done) begin
          err_d = 1'b0;
          if (rh_wl_q) begin
            rdata_d = i2c_data_r;
            state_d = RESP;
          end else begin
            cnt_d   = 16'd0;
            state_d = WR_WAIT;
          end
        end else if (cnt_q >= TO_LAST) begin
          err_d   = 1'b1;
          rdata_d = 8'h00;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      WR_WAIT: begin
        if (cnt_q == WR_LAST) state_d = RESP;
        else                  cnt_d   = cnt_q + 16'd1;
      end
      RESP: begin
        last_grant_d = grant_id_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_id_q   <= 1'b0;
      last_grant_q <= 1'b1;
      rh_wl_q      <= 1'b0;
      addr_q       <= 16'h0000;
      wdata_q      <= 8'h00;
      rdata_q      <= 8'h00;
      err_q        <= 1'b0;
      cnt_q        <= 16'd0;
    end else begin
      state_q      <= state_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
      rh_wl_q      <= rh_wl_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
    end
  end

  assign req0_ready  = grant0;
  assign req1_ready  = grant1;
  assign i2c_exec    = (state_q == ISSUE);
  assign resp0_valid = (state_q == RESP) && !grant_id_q;
  assign resp1_valid = (state_q == RESP) &&  grant_id_q;
  assign resp_rdata  = (state_q == RESP) ? rdata_q : 8'h00;
  assign resp_err    = (state_q == RESP) && err_q;
  assign i2c_rh_wl   = rh_wl_q;
  assign i2c_addr    = addr_q;
  assign i2c_data_w  = wdata_q;
  assign bit_ctrl    = BIT_CTRL;
  assign busy        = (state_q != IDLE);

endmodule
